// File: rtl/hw1_func_scanner.sv
// Self-test scanner for the 4-input function block: steps ABCD through all
// sixteen minterms, samples F after a settle window, and reports how the
// observed truth table compares with the golden mask.
module hw1_func_scanner #(
   parameter int unsigned SETTLE_CYCLES = 1,
   parameter logic [15:0] GOLDEN        = 16'h3F75
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   output logic        A,
   output logic        B,
   output logic        C,
   output logic        D,
   input  logic        F,
   output logic        busy,
   output logic        done,
   output logic        pass,
   output logic [15:0] truth,
   output logic [4:0]  err_cnt,
   output logic [3:0]  first_bad
);

   typedef enum logic [1:0] {
      IDLE,
      SETTLE,
      SAMPLE,
      FINISH
   } state_t;

   localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

   state_t      state_q, state_d;
   logic [3:0]  idx_q, idx_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;
   logic        pass_q, pass_d;
   logic [15:0] truth_q, truth_d;
   logic [4:0]  errCnt_q, errCnt_d;
   logic [3:0]  firstBad_q, firstBad_d;
   logic        mismatch;

   // The function result disagrees with the golden mask for the current minterm
   assign mismatch = (F != GOLDEN[idx_q]);

   // Next-state and result bookkeeping: results are cleared only when a new
   // scan is accepted, so they stay readable in IDLE after a scan finishes
   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      cnt_d      = cnt_q;
      busy_d     = busy_q;
      done_d     = 1'b0;
      pass_d     = pass_q;
      truth_d    = truth_q;
      errCnt_d   = errCnt_q;
      firstBad_d = firstBad_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d    = SETTLE;
               idx_d      = 4'd0;
               cnt_d      = 4'd0;
               busy_d     = 1'b1;
               pass_d     = 1'b0;
               truth_d    = 16'h0000;
               errCnt_d   = 5'd0;
               firstBad_d = 4'd0;
            end
         end
         SETTLE: begin
            if (cnt_q == SETTLE_LAST) begin
               state_d = SAMPLE;
               cnt_d   = 4'd0;
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         SAMPLE: begin
            truth_d[idx_q] = F;
            if (mismatch) begin
               errCnt_d = errCnt_q + 5'd1;
               if (errCnt_q == 5'd0) begin
                  firstBad_d = idx_q;
               end
            end
            if (idx_q == 4'd15) begin
               state_d = FINISH;
               idx_d   = 4'd0;
               done_d  = 1'b1;
               pass_d  = (errCnt_q == 5'd0) && !mismatch;
            end else begin
               state_d = SETTLE;
               idx_d   = idx_q + 4'd1;
            end
         end
         FINISH: begin
            state_d = IDLE;
            busy_d  = 1'b0;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and result registers; reset discards any scan in progress
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         idx_q      <= 4'd0;
         cnt_q      <= 4'd0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         pass_q     <= 1'b0;
         truth_q    <= 16'h0000;
         errCnt_q   <= 5'd0;
         firstBad_q <= 4'd0;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         cnt_q      <= cnt_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         pass_q     <= pass_d;
         truth_q    <= truth_d;
         errCnt_q   <= errCnt_d;
         firstBad_q <= firstBad_d;
      end
   end

   assign {A, B, C, D} = idx_q;
   assign busy         = busy_q;
   assign done         = done_q;
   assign pass         = pass_q;
   assign truth        = truth_q;
   assign err_cnt      = errCnt_q;
   assign first_bad    = firstBad_q;

endmodule

// File: tb/tb_hw1_func_scanner.sv
// Bench for hw1_func_scanner: a fast (settle 1) and a slow (settle 3) scanner
// each look at a function block emulated by a 16-entry lookup table.
module tb_hw1_func_scanner;

   localparam logic [15:0] GOLD = 16'h3F75;

   logic        clk;
   logic        rst_n;
   logic        startFast, startSlow;
   logic [15:0] fTable;
   logic        glitchOn;

   logic        aF, bF, cF, dF, fFast, busyFast, doneFast, passFast;
   logic [15:0] truthFast;
   logic [4:0]  errFast;
   logic [3:0]  firstFast;

   logic        aS, bS, cS, dS, fSlow, busySlow, doneSlow, passSlow;
   logic [15:0] truthSlow;
   logic [4:0]  errSlow;
   logic [3:0]  firstSlow;

   logic [31:0] fastOuts;

   int testsRun;
   int testsFailed;

   typedef struct {
      logic        slow;
      logic [15:0] tbl;
      logic [15:0] expTruth;
      logic [4:0]  expErr;
      logic [3:0]  expFirst;
      logic        expPass;
      logic        glitch;
   } vec_t;

   vec_t vecs[8];

   hw1_func_scanner #(.SETTLE_CYCLES(1), .GOLDEN(GOLD)) dutFast (
      .clk(clk), .rst_n(rst_n), .start(startFast),
      .A(aF), .B(bF), .C(cF), .D(dF), .F(fFast),
      .busy(busyFast), .done(doneFast), .pass(passFast),
      .truth(truthFast), .err_cnt(errFast), .first_bad(firstFast)
   );

   hw1_func_scanner #(.SETTLE_CYCLES(3), .GOLDEN(GOLD)) dutSlow (
      .clk(clk), .rst_n(rst_n), .start(startSlow),
      .A(aS), .B(bS), .C(cS), .D(dS), .F(fSlow),
      .busy(busySlow), .done(doneSlow), .pass(passSlow),
      .truth(truthSlow), .err_cnt(errSlow), .first_bad(firstSlow)
   );

   // Emulated function blocks, with an optional glitch overlaid on F
   assign fFast = fTable[{aF, bF, cF, dF}] ^ glitchOn;
   assign fSlow = fTable[{aS, bS, cS, dS}] ^ glitchOn;

   assign fastOuts = {aF, bF, cF, dF, busyFast, doneFast, passFast, truthFast, errFast, firstFast};

   // Free-running clock, rising edges at 5, 15, 25, ...
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      testsRun++;
      if (actual !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   // Reference model straight from the comparison rules: every minterm whose
   // function value differs from the golden mask counts, the lowest one is reported
   function automatic void modelScan(input logic [15:0] tbl, output logic [4:0] err,
                                     output logic [3:0] first, output logic ok);
      logic [15:0] diff;
      bit found;
      diff  = tbl ^ GOLD;
      err   = 5'd0;
      first = 4'd0;
      found = 0;
      for (int m = 0; m < 16; m++) begin
         if (diff[m]) begin
            err = err + 5'd1;
            if (!found) first = 4'(m);
            found = 1;
         end
      end
      ok = (diff == 16'h0000);
   endfunction

   // Runs one complete scan on the chosen scanner, checking the cycle-by-cycle
   // busy/done/ABCD timeline and the final results
   task automatic applyStimulus(input logic slow, input logic [15:0] tbl, input logic [15:0] expTruth,
                                input logic [4:0] expErr, input logic [3:0] expFirst, input logic expPass,
                                input logic glitch, input logic repulse, input string tag);
      int         per;
      int         doneCycle;
      bit         busyBad, doneBad, abcdBad;
      logic       passAtDone;
      logic       obsBusy, obsDone, obsPass, stb;
      logic [3:0] obsAbcd, expAbcd;
      per        = slow ? 4 : 2;
      doneCycle  = 1 + 16 * per;
      busyBad    = 0;
      doneBad    = 0;
      abcdBad    = 0;
      passAtDone = 1'bx;
      fTable     = tbl;
      @(negedge clk);
      if (slow) startSlow = 1'b1; else startFast = 1'b1;
      @(negedge clk);
      startSlow = 1'b0;
      startFast = 1'b0;
      for (int c = 1; c <= doneCycle + 1; c++) begin
         obsBusy = slow ? busySlow : busyFast;
         obsDone = slow ? doneSlow : doneFast;
         obsPass = slow ? passSlow : passFast;
         obsAbcd = slow ? {aS, bS, cS, dS} : {aF, bF, cF, dF};
         expAbcd = (c < doneCycle) ? 4'((c - 1) / per) : 4'd0;
         if (obsBusy !== (c <= doneCycle)) busyBad = 1;
         if (obsDone !== (c == doneCycle)) doneBad = 1;
         if (obsAbcd !== expAbcd) abcdBad = 1;
         if (c == doneCycle) passAtDone = obsPass;
         glitchOn = glitch && (c < doneCycle) && (((c - 1) % per) != (per - 1));
         stb = repulse && (c == 5 || c == 20);
         if (slow) startSlow = stb; else startFast = stb;
         @(negedge clk);
      end
      glitchOn  = 1'b0;
      startSlow = 1'b0;
      startFast = 1'b0;
      checkOutput({tag, "/busySeq"}, 32'(busyBad), 32'd0);
      checkOutput({tag, "/doneSeq"}, 32'(doneBad), 32'd0);
      checkOutput({tag, "/abcdSeq"}, 32'(abcdBad), 32'd0);
      checkOutput({tag, "/passAtDone"}, 32'(passAtDone), 32'(expPass));
      checkOutput({tag, "/truth"}, 32'(slow ? truthSlow : truthFast), 32'(expTruth));
      checkOutput({tag, "/errCnt"}, 32'(slow ? errSlow : errFast), 32'(expErr));
      checkOutput({tag, "/firstBad"}, 32'(slow ? firstSlow : firstFast), 32'(expFirst));
      checkOutput({tag, "/passHeld"}, 32'(slow ? passSlow : passFast), 32'(expPass));
   endtask

   // Main sequence: reset, vector table, corner sequences, random functions
   initial begin
      logic [15:0] rTbl;
      logic [4:0]  mErr;
      logic [3:0]  mFirst;
      logic        mPass;
      int          waited;
      testsRun    = 0;
      testsFailed = 0;
      startFast   = 1'b0;
      startSlow   = 1'b0;
      fTable      = GOLD;
      glitchOn    = 1'b0;
      rst_n       = 1'b1;

      #1 rst_n = 1'b0;
      #1;
      checkOutput("reset/fastOuts", fastOuts, 32'd0);
      checkOutput("reset/slowBusyAbcd", 32'({busySlow, aS, bS, cS, dS, truthSlow}), 32'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      vecs[0] = '{1'b0, 16'h3F75, 16'h3F75, 5'd0,  4'd0,  1'b1, 1'b0};
      vecs[1] = '{1'b0, 16'h0000, 16'h0000, 5'd11, 4'd0,  1'b0, 1'b0};
      vecs[2] = '{1'b0, 16'hFFFF, 16'hFFFF, 5'd5,  4'd1,  1'b0, 1'b0};
      vecs[3] = '{1'b1, 16'h3F75, 16'h3F75, 5'd0,  4'd0,  1'b1, 1'b0};
      vecs[4] = '{1'b0, 16'hC08A, 16'hC08A, 5'd16, 4'd0,  1'b0, 1'b0};
      vecs[5] = '{1'b0, 16'hBF75, 16'hBF75, 5'd1,  4'd15, 1'b0, 1'b0};
      vecs[6] = '{1'b1, 16'h3F77, 16'h3F77, 5'd1,  4'd1,  1'b0, 1'b0};
      vecs[7] = '{1'b0, 16'h3F75, 16'h3F75, 5'd0,  4'd0,  1'b1, 1'b1};

      for (int i = 0; i < 8; i++) begin
         applyStimulus(vecs[i].slow, vecs[i].tbl, vecs[i].expTruth, vecs[i].expErr,
                       vecs[i].expFirst, vecs[i].expPass, vecs[i].glitch, 1'b0,
                       $sformatf("vec%0d", i));
      end

      repeat (5) @(negedge clk);
      checkOutput("idleHold/truth", 32'(truthFast), 32'h3F75);
      checkOutput("idleHold/pass", 32'(passFast), 32'd1);

      applyStimulus(1'b0, GOLD, GOLD, 5'd0, 4'd0, 1'b1, 1'b0, 1'b1, "repulse");

      fTable = GOLD;
      @(negedge clk);
      startFast = 1'b1;
      @(negedge clk);
      startFast = 1'b0;
      waited = 0;
      while ({aF, bF, cF, dF} != 4'd7 && waited < 40) begin
         @(negedge clk);
         waited++;
      end
      checkOutput("midReset/reachIdx7", 32'({aF, bF, cF, dF}), 32'd7);
      #2 rst_n = 1'b0;
      #1;
      checkOutput("midReset/asyncClear", fastOuts, 32'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      checkOutput("midReset/heldClear", fastOuts, 32'd0);
      rst_n = 1'b1;
      applyStimulus(1'b0, GOLD, GOLD, 5'd0, 4'd0, 1'b1, 1'b0, 1'b0, "afterReset");

      for (int r = 0; r < 10; r++) begin
         rTbl = 16'($urandom);
         if ($urandom_range(0, 2) == 0) rTbl = GOLD ^ (16'd1 << $urandom_range(0, 15));
         if ($urandom_range(0, 4) == 0) rTbl = GOLD;
         modelScan(rTbl, mErr, mFirst, mPass);
         applyStimulus(1'($urandom_range(0, 1)), rTbl, rTbl, mErr, mFirst, mPass,
                       1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                       $sformatf("rand%0d", r));
      end

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
